ram_burst_reader: RTL and testbench

Read-side engine for the dual-port RAM. On a `start` command it streams `len` consecutive words, beginning at `base_addr`, out of one RAM port. It emits them on a valid/ready stream with `m_last` on the final beat. It hides the RAM's one-cycle registered read latency and absorbs downstream backpressure without dropping or duplicating words; the writer side fills the RAM through the other port.

---
 rtl/ram_pkg.sv | 28 ++
 rtl/ram_rd_skid.sv | 73 +++++++
 rtl/ram_burst_reader.sv | 174 +++++++++++++++++
 tb/tb_ram_burst_reader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_pkg
// Description : Shared constants, read-FSM state encoding and skid-pointer
//               helper for the dual-port RAM burst reader.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

    localparam int RAM_DATA_W    = 128;
    localparam int RAM_ADDR_W    = 3;
    localparam int RD_SKID_DEPTH = 3;
    localparam int RD_PTR_W      = 2;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_READ  = 2'd1,
        RD_DRAIN = 2'd2,
        RD_DONE  = 2'd3
    } rd_state_t;

    // Pointer wrap for a non-power-of-two FIFO depth
    function automatic logic [RD_PTR_W-1:0] skid_ptr_inc(input logic [RD_PTR_W-1:0] p);
        return (p == RD_PTR_W'(RD_SKID_DEPTH - 1)) ? '0 : p + RD_PTR_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_rd_skid.sv
`default_nettype none
// ============================================================================
// Module      : ram_rd_skid
// Description : 3-entry FIFO of {last, data} absorbing downstream backpressure
//               behind the RAM read pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_rd_skid
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              push_last,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic              head_last,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        count
);

    logic [DATA_W:0]     mem_q [RD_SKID_DEPTH];
    logic [DATA_W:0]     mem_d [RD_SKID_DEPTH];
    logic [RD_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [RD_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;
    logic                w_push, w_pop;

    always_comb begin
        w_pop    = pop && (count_q != 2'd0);
        // A full FIFO may still take a push when the head leaves in the same cycle
        w_push   = push && ((count_q != 2'(RD_SKID_DEPTH)) || w_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = {push_last, push_data};
            wr_ptr_d        = skid_ptr_inc(wr_ptr_q);
        end
        if (w_pop) begin
            rd_ptr_d = skid_ptr_inc(rd_ptr_q);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid                  = (count_q != 2'd0);
    assign {head_last, head_data} = mem_q[rd_ptr_q];
    assign count                  = count_q;

endmodule
`default_nettype wire

// File: rtl/ram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : ram_burst_reader
// Description : Streams len consecutive RAM words from base_addr onto a
//               valid/ready stream, hiding the one-cycle RAM read latency.
//               Optional RAM_BURST_READER_CKSUM_EN adds an XOR checksum port.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_burst_reader
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr_en,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
`ifdef RAM_BURST_READER_CKSUM_EN
    ,
    output logic [DATA_W-1:0] cksum
`endif
);

    localparam int CNT_W = ADDR_W + 1;

    rd_state_t         state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              s0_q, s0_d, s0_last_q, s0_last_d;
    logic              s1_q, s1_d, s1_last_q, s1_last_d;

    logic              w_head_last;
    logic [1:0]        w_count;
    logic              w_hs, w_room, w_issue, w_issue_last;
    logic [2:0]        w_occ;

    always_comb begin
        w_hs         = m_valid && m_ready;
        // Words buffered plus words still in the RAM pipe must fit the skid FIFO
        w_occ        = {1'b0, w_count} + {2'b00, s0_q} + {2'b00, s1_q};
        w_room       = w_occ < (3'(RD_SKID_DEPTH) + {2'b00, w_hs});
        w_issue      = 1'b0;
        w_issue_last = 1'b0;
        state_d      = state_q;
        len_d        = len_q;
        issued_d     = issued_q;
        ram_addr_d   = ram_addr_q;

        case (state_q)
            RD_IDLE: begin
                if (start) begin
                    len_d    = len;
                    issued_d = '0;
                    if (len == '0) begin
                        state_d = RD_DONE;
                    end else begin
                        w_issue      = 1'b1;
                        w_issue_last = (len == CNT_W'(1));
                        ram_addr_d   = base_addr;
                        issued_d     = CNT_W'(1);
                        state_d      = RD_READ;
                    end
                end
            end
            RD_READ: begin
                if (issued_q == len_q) begin
                    state_d = RD_DRAIN;
                end else if (w_room) begin
                    w_issue      = 1'b1;
                    w_issue_last = ((issued_q + CNT_W'(1)) == len_q);
                    ram_addr_d   = ram_addr_q + ADDR_W'(1);
                    issued_d     = issued_q + CNT_W'(1);
                end
            end
            RD_DRAIN: begin
                if (w_hs && w_head_last) begin
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase

        s0_d      = w_issue;
        s0_last_d = w_issue_last;
        s1_d      = s0_q;
        s1_last_d = s0_last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RD_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            ram_addr_q <= '0;
            s0_q       <= 1'b0;
            s0_last_q  <= 1'b0;
            s1_q       <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            ram_addr_q <= ram_addr_d;
            s0_q       <= s0_d;
            s0_last_q  <= s0_last_d;
            s1_q       <= s1_d;
            s1_last_q  <= s1_last_d;
        end
    end

    // Stage 1 marks the edge at which ram_rdata holds the word for that tag
    ram_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_q),
        .push_last (s1_last_q),
        .push_data (ram_rdata),
        .pop       (w_hs),
        .valid     (m_valid),
        .head_last (w_head_last),
        .head_data (m_data),
        .count     (w_count)
    );

    assign m_last    = m_valid && w_head_last;
    assign busy      = (state_q != RD_IDLE);
    assign done      = (state_q == RD_DONE);
    assign ram_addr  = ram_addr_q;
    assign ram_wr_en = 1'b0;

`ifdef RAM_BURST_READER_CKSUM_EN
    logic [DATA_W-1:0] cksum_q, cksum_d;

    always_comb begin
        cksum_d = cksum_q;
        if (state_q == RD_IDLE && start) begin
            cksum_d = '0;
        end else if (w_hs) begin
            cksum_d = cksum_q ^ m_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign cksum = cksum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_burst_reader
// Description : Self-checking bench for ram_burst_reader with a registered
//               RAM model and a beat scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_burst_reader;

    localparam int DW    = 128;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy, done;
    logic [AW-1:0] ram_addr;
    logic          ram_wr_en;
    logic [DW-1:0] ram_rdata;
    logic          m_valid, m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [DW-1:0] cksum;

    ram_burst_reader #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_wr_en (ram_wr_en),
        .ram_rdata (ram_rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
`ifdef RAM_BURST_READER_CKSUM_EN
        ,
        .cksum     (cksum)
`endif
    );

`ifndef RAM_BURST_READER_CKSUM_EN
    assign cksum = '0;
`endif

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(input int a);
        return {64'hAAAA0000AAAA0000, 64'(a % DEPTH)};
    endfunction

    // Registered-read RAM port
    always @(posedge clk) ram_rdata <= word(int'(ram_addr));

    typedef struct {
        logic          last;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        int            mode;
        bit            extra;
        int            exp_first_v;
        int            exp_done_cyc;
    } vec_t;
    vec_t vecs[7];

    int total = 0;
    int bad   = 0;

    int            delivered = 0;
    logic [AW-1:0] cur_base  = '0;
    bit            track_en  = 1'b0;
    int            max_ahead = 0;
    bit            wr_en_err = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   ahead;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (ram_wr_en !== 1'b0) wr_en_err = 1'b1;
            if (track_en && busy && !done && delivered < 8) begin
                ahead = int'(3'(ram_addr - cur_base)) + 1 - delivered;
                if (ahead > max_ahead) max_ahead = ahead;
            end
            if (prev_stall && m_valid) begin
                check("stall_data", m_data, prev_data);
                check("stall_last", DW'(m_last), DW'(prev_last));
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got data %0h, want no beat", m_data);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", m_data, e.data);
                    check("beat_last", DW'(m_last), DW'(e.last));
                end
                delivered++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] l, input int mode,
                             input bit extra, output int first_v, output int done_cyc,
                             output int n_done, output logic [DW-1:0] ck);
        logic [3:0] pat = 4'b1001;
        first_v  = -1;
        done_cyc = -1;
        n_done   = 0;
        ck       = '0;
        start     = 1'b1;
        base_addr = b;
        len       = l;
        for (int i = 0; i < int'(l); i++) begin
            sb.push_back('{last: (i == int'(l) - 1), data: word(int'(b) + i)});
        end
        cur_base  = b;
        delivered = 0;
        @(posedge clk); #1;
        for (int c = 1; c < 200; c++) begin
            m_ready = (mode == 0) ? 1'b1 : pat[c % 4];
            if (extra && c == 2) begin
                start     = 1'b1;
                base_addr = 3'd4;
                len       = 4'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (c == 1 && l != '0) begin
                check("addr_after_start", DW'(ram_addr), DW'(b));
                check("busy_after_start", DW'(busy), DW'(1'b1));
            end
            if (m_valid && first_v < 0) first_v = c;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
                ck = cksum;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                check("busy_after_done", DW'(busy), DW'(1'b0));
                break;
            end
            @(posedge clk); #1;
        end
        if (done_cyc < 0) begin
            total++;
            bad++;
            $display("FAIL burst_timeout: got no done, want done within 200 cycles");
        end
        @(posedge clk); #1;
        start   = 1'b0;
        m_ready = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running, want finish");
        $fatal(1);
    end

    initial begin
        int            fv, dc, nd;
        logic [DW-1:0] ck;
        logic [AW-1:0] addr_before;
        bit            hit;
        int            rst_done, rst_valid;

        vecs[0] = '{3'd0, 4'd8,  0, 1'b0,  3, 11};
        vecs[1] = '{3'd6, 4'd4,  0, 1'b0,  3,  7};
        vecs[2] = '{3'd0, 4'd8,  1, 1'b0,  3, -1};
        vecs[3] = '{3'd0, 4'd0,  0, 1'b0, -1,  1};
        vecs[4] = '{3'd5, 4'd1,  0, 1'b0,  3,  4};
        vecs[5] = '{3'd3, 4'd10, 0, 1'b0,  3, 13};
        vecs[6] = '{3'd1, 4'd3,  0, 1'b1,  3,  6};

        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",    DW'(busy),      '0);
        check("rst_done",    DW'(done),      '0);
        check("rst_addr",    DW'(ram_addr),  '0);
        check("rst_wr_en",   DW'(ram_wr_en), '0);
        check("rst_m_valid", DW'(m_valid),   '0);
        check("rst_m_last",  DW'(m_last),    '0);
        check("rst_m_data",  m_data,         '0);
        rst = 1'b0;
        m_ready = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            addr_before = ram_addr;
            track_en    = (vecs[v].mode == 1);
            max_ahead   = 0;
            run_burst(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].extra, fv, dc, nd, ck);
            track_en = 1'b0;
            check("first_valid_cycle", DW'(fv), DW'(vecs[v].exp_first_v));
            if (vecs[v].exp_done_cyc >= 0)
                check("done_cycle", DW'(dc), DW'(vecs[v].exp_done_cyc));
            check("done_pulses", DW'(nd), DW'(1));
            check("sb_drained", DW'(sb.size()), '0);
            if (vecs[v].len == '0)
                check("len0_addr_kept", DW'(ram_addr), DW'(addr_before));
            if (vecs[v].mode == 1)
                check("max_ahead_le3", DW'(max_ahead <= 3), DW'(1));
        end

        // Reset while the third beat is on the stream
        start = 1'b1; base_addr = 3'd0; len = 4'd8; m_ready = 1'b1;
        for (int i = 0; i < 8; i++) sb.push_back('{last: (i == 7), data: word(i)});
        cur_base = '0;
        delivered = 0;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (delivered == 2 && m_valid) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("rst_third_beat_reached", DW'(hit), DW'(1'b1));
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_m_valid", DW'(m_valid), '0);
        check("midrst_busy",    DW'(busy),    '0);
        check("midrst_done",    DW'(done),    '0);
        rst = 1'b0;
        sb.delete();
        rst_done = 0;
        rst_valid = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) rst_done++;
            if (m_valid) rst_valid++;
            @(posedge clk); #1;
        end
        check("midrst_no_done",  DW'(rst_done),  '0);
        check("midrst_no_valid", DW'(rst_valid), '0);
        run_burst(3'd2, 4'd2, 0, 1'b0, fv, dc, nd, ck);
        check("post_rst_first_valid", DW'(fv), DW'(3));
        check("post_rst_done_cycle",  DW'(dc), DW'(5));
        check("post_rst_sb_drained",  DW'(sb.size()), '0);

`ifdef RAM_BURST_READER_CKSUM_EN
        run_burst(3'd0, 4'd2, 0, 1'b0, fv, dc, nd, ck);
        check("cksum_len2", ck, {64'h0, 64'h1});
`endif

        check("wr_en_never_set", DW'(wr_en_err), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
